pipe_addsub: RTL and testbench

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/addsub_pkg.sv | 9 +
 rtl/addsub_chunk.sv | 19 +
 rtl/pipe_addsub.sv | 100 ++++++++++
 tb/tb_pipe_addsub.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared defaults and stage-count helper for the chunked pipelined adder/subtractor.
package addsub_pkg;
  localparam int N_DEF = 16;
  localparam int K_DEF = 4;

  function automatic int calc_stages(input int n, input int k);
    return (k > 0) ? n / k : 1;
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// Combinational K-bit chunk adder: sum, carry-out and carry into the chunk MSB.
module addsub_chunk #(
  parameter int K = 4
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  logic         ci_i,
  output logic [K-1:0] s_o,
  output logic         co_o,
  output logic         cmsb_o
);
  logic [K:0] t;

  assign t      = {1'b0, a_i} + {1'b0, b_i} + {{K{1'b0}}, ci_i};
  assign s_o    = t[K-1:0];
  assign co_o   = t[K];
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by xor
  assign cmsb_o = a_i[K-1] ^ b_i[K-1] ^ t[K-1];
endmodule

// File: rtl/pipe_addsub.sv
// N-bit add/sub pipelined K bits per stage; operands travel skewed, sums deskewed,
// so one beat per cycle emerges aligned after S = N/K cycles.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int S = calc_stages(N, K);

  if (K < 1) begin : g_bad_k
    $error("pipe_addsub: K must be >= 1");
  end else if (N % K != 0) begin : g_bad_nk
    $error("pipe_addsub: N must be a multiple of K");
  end

  logic [S-1:0]        vld_pipe_q;
  logic [S-1:0][N-1:0] a_q, b_q, sum_q;
  logic [S-1:0]        c_q;
  logic                ovf_q;

  logic [S-1:0][N-1:0] a_in, b_in, s_in, s_d;
  logic [S-1:0]        c_in;
  logic [S-1:0][K-1:0] ch_s;
  logic [S-1:0]        ch_co, ch_cm;
  logic                stall;

  assign stall     = vld_pipe_q[S-1] && !out_ready;
  assign in_ready  = !rst_n || !stall;
  assign out_valid = vld_pipe_q[S-1];
  assign sum       = sum_q[S-1];
  assign cout      = c_q[S-1];
  assign ovf       = ovf_q;

  // subtraction folds into the adder as a + ~b + 1
  always_comb begin
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub ? 1'b1 : cin;
    s_in[0] = '0;
    for (int j = 1; j < S; j++) begin
      a_in[j] = a_q[j-1];
      b_in[j] = b_q[j-1];
      c_in[j] = c_q[j-1];
      s_in[j] = sum_q[j-1];
    end
    for (int j = 0; j < S; j++) begin
      s_d[j]          = s_in[j];
      s_d[j][j*K +: K] = ch_s[j];
    end
  end

  for (genvar j = 0; j < S; j++) begin : g_stage
    addsub_chunk #(.K(K)) u_chunk (
      .a_i    (a_in[j][j*K +: K]),
      .b_i    (b_in[j][j*K +: K]),
      .ci_i   (c_in[j]),
      .s_o    (ch_s[j]),
      .co_o   (ch_co[j]),
      .cmsb_o (ch_cm[j])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      c_q        <= '0;
      ovf_q      <= 1'b0;
    end else if (!stall) begin
      vld_pipe_q[0] <= in_valid;
      for (int j = 1; j < S; j++) vld_pipe_q[j] <= vld_pipe_q[j-1];
      a_q   <= a_in;
      b_q   <= b_in;
      sum_q <= s_d;
      c_q   <= ch_co;
      ovf_q <= ch_cm[S-1] ^ ch_co[S-1];
    end
  end

  // last-stage operand copies and inner-chunk MSB carries have no consumer
  logic unused_bits;
  assign unused_bits = ^{a_q[S-1], b_q[S-1], ch_cm};
endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub (N=16, K=4): model results queued at acceptance,
// compared in order when the DUT hands a result downstream.
module tb_pipe_addsub;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  pipe_addsub #(.N(16), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          lat_chk = 1'b1;
  bit          held_v  = 1'b0;
  logic [15:0] held_s;
  logic        held_c, held_o;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference: plain 17-bit add; overflow from operand/result sign rule
  function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb,
                                 input logic ci, input logic sb, input int t);
    exp_t        e;
    logic [15:0] bx;
    logic [16:0] r;
    bx  = sb ? ~bb : bb;
    r   = {1'b0, aa} + {1'b0, bx} + {16'd0, (sb ? 1'b1 : ci)};
    e.s = r[15:0];
    e.c = r[16];
    e.o = (aa[15] == bx[15]) && (r[15] != aa[15]);
    e.t = t;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (out_valid) begin
        if (held_v) begin
          chk("hold_sum",  {16'd0, sum},  {16'd0, held_s});
          chk("hold_cout", {31'd0, cout}, {31'd0, held_c});
          chk("hold_ovf",  {31'd0, ovf},  {31'd0, held_o});
        end
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
          held_v = 1'b0;
        end else if (out_ready) begin
          e = q.pop_front();
          chk("sum",  {16'd0, sum},  {16'd0, e.s});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("ovf",  {31'd0, ovf},  {31'd0, e.o});
          if (lat_chk) chk("latency", cyc - e.t, 32'd4);
          held_v = 1'b0;
        end else begin
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          held_v = 1'b1;
          held_s = sum;
          held_c = cout;
          held_o = ovf;
        end
      end else begin
        held_v = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, cyc));
    end
  end

  task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic ci, input logic sb);
    bit ok;
    ok = 1'b0;
    a = aa; b = bb; cin = ci; sub = sb; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_left", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // directed corner cases, one at a time
    send(16'h1234, 16'h1111, 1'b0, 1'b0); wait_drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_drain();
    send(16'h0000, 16'h0001, 1'b0, 1'b1); wait_drain();
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0); wait_drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b1); wait_drain();

    // back-to-back burst
    for (int i = 0; i < 20; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    wait_drain();

    // fill the pipe, then stall output for 6 cycles with a beat offered
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_ready_low", {31'd0, in_ready}, 32'd0);
      chk("stall_valid_hi",  {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    wait_drain();
    lat_chk = 1'b1;

    // reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flushed_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
